prog_loader: RTL and testbench

- Writes a program image into the CPU's instruction memory before execution.
- Accepts a framed byte stream on a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Drives the instruction memory's write port (address, data-in, write-enable) and verifies a trailing XOR checksum.
- Raises a sticky cpu_run once the image is loaded cleanly. The CPU is the reader of instruction memory; this block is its writer.

---
 rtl/prog_loader.sv | 159 +++++++++++++++
 tb/tb_prog_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles a framed, checksummed byte stream into
// big-endian words, writes them from START_ADDR upward, then releases the CPU.
module prog_loader #(
  parameter int unsigned N          = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned START_ADDR = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         rearm,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_data,
  output logic         mem_we,
  output logic         cpu_run,
  output logic         load_err,
  output logic [1:0]   err_code
);

  localparam int unsigned MAX_CNT = DEPTH - START_ADDR;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t         state, state_d;
  logic [7:0]     cnt_hi, cnt_hi_d;
  logic [7:0]     hi_byte, hi_byte_d;
  logic [7:0]     xsum, xsum_d;
  logic [15:0]    remain, remain_d;
  logic [N-1:0]   wptr, wptr_d;
  logic [N-1:0]   mem_addr_d, mem_data_d;
  logic           mem_we_d, cpu_run_d, load_err_d, in_ready_d;
  logic [1:0]     err_code_d;
  logic           accept_c;
  logic [15:0]    count_c;

  assign accept_c = in_valid && in_ready;
  assign count_c  = {cnt_hi, in_data};

  // Next-state and next-output logic; every register holds unless updated.
  always_comb begin
    state_d    = state;
    cnt_hi_d   = cnt_hi;
    hi_byte_d  = hi_byte;
    xsum_d     = xsum;
    remain_d   = remain;
    wptr_d     = wptr;
    mem_addr_d = mem_addr;
    mem_data_d = mem_data;
    mem_we_d   = 1'b0;
    cpu_run_d  = cpu_run;
    load_err_d = load_err;
    err_code_d = err_code;

    // The checksum byte itself is never folded into the running XOR.
    if (accept_c && state != S_CHK) xsum_d = xsum ^ in_data;

    case (state)
      S_IDLE: begin
        if (accept_c) begin
          cnt_hi_d = in_data;
          state_d  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept_c) begin
          remain_d = count_c;
          if (32'(count_c) > MAX_CNT) begin
            state_d    = S_ERROR;
            load_err_d = 1'b1;
            err_code_d = 2'd2;
          end else if (count_c == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept_c) begin
          hi_byte_d = in_data;
          state_d   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept_c) begin
          mem_we_d   = 1'b1;
          mem_addr_d = wptr;
          mem_data_d = N'({hi_byte, in_data});
          wptr_d     = wptr + N'(1);
          remain_d   = remain - 16'd1;
          state_d    = (remain == 16'd1) ? S_CHK : S_DATA_HI;
        end
      end
      S_CHK: begin
        if (accept_c) begin
          if (in_data == xsum) begin
            state_d   = S_DONE;
            cpu_run_d = 1'b1;
          end else begin
            state_d    = S_ERROR;
            load_err_d = 1'b1;
            err_code_d = 2'd1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (rearm) begin
          state_d    = S_IDLE;
          cpu_run_d  = 1'b0;
          load_err_d = 1'b0;
          err_code_d = 2'd0;
          xsum_d     = 8'd0;
          wptr_d     = N'(START_ADDR);
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = !(state_d == S_DONE || state_d == S_ERROR);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt_hi   <= 8'd0;
      hi_byte  <= 8'd0;
      xsum     <= 8'd0;
      remain   <= 16'd0;
      wptr     <= N'(START_ADDR);
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      cpu_run  <= 1'b0;
      load_err <= 1'b0;
      err_code <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_d;
      cnt_hi   <= cnt_hi_d;
      hi_byte  <= hi_byte_d;
      xsum     <= xsum_d;
      remain   <= remain_d;
      wptr     <= wptr_d;
      mem_addr <= mem_addr_d;
      mem_data <= mem_data_d;
      mem_we   <= mem_we_d;
      cpu_run  <= cpu_run_d;
      load_err <= load_err_d;
      err_code <= err_code_d;
      in_ready <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames
// scored against a frame-level model of expected writes and final status.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rearm;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        cpu_run;
  logic        load_err;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] words[$];

  prog_loader #(.N(16), .DEPTH(1024), .START_ADDR(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rearm(rearm), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .cpu_run(cpu_run),
    .load_err(load_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Capture every write pulse as {addr, data}.
  always @(negedge clk) if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_rearm();
    @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    check("rearm_in_ready", 32'(in_ready), 32'd1);
    check("rearm_cpu_run", 32'(cpu_run), 32'd0);
    check("rearm_load_err", 32'(load_err), 32'd0);
    check("rearm_err_code", 32'(err_code), 32'd0);
  endtask

  // Send one frame of cnt words (taken from words[]) and score it.
  task automatic run_frame(input int cnt, input bit bad, input int maxgap);
    logic [7:0]  x;
    logic [15:0] c;
    bit          ovf;
    int          exp_code;
    int          m;
    c = 16'(cnt);
    x = 8'd0;
    got_q.delete();
    exp_q.delete();
    ovf = (cnt > 1023);
    send_byte(c[15:8], $urandom_range(0, maxgap)); x ^= c[15:8];
    send_byte(c[7:0],  $urandom_range(0, maxgap)); x ^= c[7:0];
    if (!ovf) begin
      for (int i = 0; i < cnt; i++) begin
        send_byte(words[i][15:8], $urandom_range(0, maxgap)); x ^= words[i][15:8];
        send_byte(words[i][7:0],  $urandom_range(0, maxgap)); x ^= words[i][7:0];
        exp_q.push_back({16'(i + 1), words[i]});
      end
      send_byte(bad ? (x ^ 8'($urandom_range(1, 255))) : x, $urandom_range(0, maxgap));
    end
    exp_code = ovf ? 2 : (bad ? 1 : 0);
    @(negedge clk);
    check("cpu_run", 32'(cpu_run), 32'(exp_code == 0));
    check("load_err", 32'(load_err), 32'(exp_code != 0));
    check("err_code", 32'(err_code), 32'(exp_code));
    check("in_ready_end", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("write_count", 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check("write_addr_data", got_q[i], exp_q[i]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; rearm = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);

    // Two-word frame, good then bad checksum.
    words = '{16'h8005, 16'hA000};
    run_frame(2, 1'b0, 0);
    pulse_rearm();
    run_frame(2, 1'b1, 0);
    pulse_rearm();

    // Count just over and exactly at capacity.
    run_frame(1024, 1'b0, 0);
    pulse_rearm();
    words.delete();
    for (int i = 0; i < 1023; i++) words.push_back(16'($urandom));
    run_frame(1023, 1'b0, 0);
    check("last_addr", 32'(mem_addr), 32'd1023);
    pulse_rearm();

    // Empty image.
    run_frame(0, 1'b0, 0);
    pulse_rearm();

    // Reset mid-frame discards the partial image; the resend succeeds.
    got_q.delete();
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'h80, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_writes", 32'(got_q.size()), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_cpu_run", 32'(cpu_run), 32'd0);
    words = '{16'h8005, 16'hA000};
    run_frame(2, 1'b0, 1);

    // Rearm from DONE and load a single word.
    pulse_rearm();
    words = '{16'h1234};
    run_frame(1, 1'b0, 0);

    // Randomized frames.
    for (int t = 0; t < 25; t++) begin
      int cnt;
      pulse_rearm();
      cnt = $urandom_range(0, 8);
      if ($urandom_range(0, 9) == 0) cnt = $urandom_range(1024, 65535);
      words.delete();
      for (int i = 0; i < 8; i++) words.push_back(16'($urandom));
      run_frame(cnt, ($urandom_range(0, 3) == 0), 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
